// File: rtl/button_mmio.sv
//==============================================================================
// Module   : button_mmio
// Brief    : Memory-mapped push-button peripheral: sync, debounce, press latch.
//            Optional interrupt output enabled by macro BUTTON_MMIO_IRQ_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module button_mmio #(
    parameter logic [31:0] BASE_ADDR       = 32'd1000,
    parameter int          DEBOUNCE_CYCLES = 16,
    parameter int          CNT_W           = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        button_in,
    input  logic [31:0] address_dmem,
    input  logic        wren,
    input  logic [31:0] data,
    input  logic        rd_strobe,
`ifdef BUTTON_MMIO_IRQ_EN
    output logic        irq,
`endif
    output logic        sel,
    output logic [31:0] q_button
);

    localparam logic [15:0] c_stab_max = 16'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_s;
    logic             r_level;
    logic [15:0]      r_stab_cnt;
    logic             r_pending;
    logic [CNT_W-1:0] r_press_cnt;

    logic             w_level_flip;
    logic             w_press;
    logic             w_clr_pend;
    logic             w_clr_cnt;
    logic             w_pending_next;
    logic [CNT_W-1:0] w_press_cnt_next;
    logic             w_ie;

    assign sel          = (address_dmem == BASE_ADDR);
    assign w_level_flip = (r_s != r_level) && (r_stab_cnt == c_stab_max);
    assign w_press      = w_level_flip & r_s;
    assign w_clr_pend   = sel & (rd_strobe | (wren & data[0]));
    assign w_clr_cnt    = sel & wren & data[1];

    // A press in the same cycle as a clear must still be recorded.
    assign w_pending_next = w_press | (r_pending & ~w_clr_pend);

    always_comb begin
        w_press_cnt_next = r_press_cnt;
        if (w_clr_cnt) begin
            w_press_cnt_next = w_press ? CNT_W'(1) : '0;
        end else if (w_press && !(&r_press_cnt)) begin
            w_press_cnt_next = r_press_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1    <= 1'b0;
            r_s        <= 1'b0;
            r_level    <= 1'b0;
            r_stab_cnt <= '0;
        end else begin
            r_sync1 <= button_in;
            r_s     <= r_sync1;
            if (r_s == r_level) begin
                r_stab_cnt <= '0;
            end else if (r_stab_cnt == c_stab_max) begin
                r_level    <= r_s;
                r_stab_cnt <= '0;
            end else begin
                r_stab_cnt <= r_stab_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pending   <= 1'b0;
            r_press_cnt <= '0;
        end else begin
            r_pending   <= w_pending_next;
            r_press_cnt <= w_press_cnt_next;
        end
    end

`ifdef BUTTON_MMIO_IRQ_EN
    logic r_ie;
    logic r_irq;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ie  <= 1'b0;
            r_irq <= 1'b0;
        end else begin
            if (wren && sel) begin
                r_ie <= data[2];
            end
            r_irq <= w_pending_next & r_ie;
        end
    end

    assign irq  = r_irq;
    assign w_ie = r_ie;

    logic w_unused_data;
    assign w_unused_data = ^data[31:3];
`else
    assign w_ie = 1'b0;

    logic w_unused_data;
    assign w_unused_data = ^data[31:2];
`endif

    always_comb begin
        q_button = '0;
        if (sel) begin
            q_button[0]           = r_level;
            q_button[1]           = r_pending;
            q_button[2]           = w_ie;
            q_button[8 +: CNT_W]  = r_press_cnt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_button_mmio.sv
//==============================================================================
// Module   : tb_button_mmio
// Brief    : Self-checking bench for button_mmio against a behavioural model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_button_mmio;

    localparam int          D    = 4;
    localparam int          CW   = 2;
    localparam logic [31:0] BASE = 32'd1000;

    logic        clock = 1'b0;
    logic        reset;
    logic        button_in;
    logic [31:0] address_dmem;
    logic        wren;
    logic [31:0] data;
    logic        rd_strobe;
    logic        sel;
    logic [31:0] q_button;
`ifdef BUTTON_MMIO_IRQ_EN
    logic        irq;
`endif

    always #5 clock = ~clock;

    button_mmio #(
        .BASE_ADDR       (BASE),
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (CW)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .button_in    (button_in),
        .address_dmem (address_dmem),
        .wren         (wren),
        .data         (data),
        .rd_strobe    (rd_strobe),
`ifdef BUTTON_MMIO_IRQ_EN
        .irq          (irq),
`endif
        .sel          (sel),
        .q_button     (q_button)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: level takes the synchronised value once it has been
    // seen for D consecutive samples; counts and flags follow the register map.
    bit m_b1, m_b2;
    bit hist[$];
    bit m_level, m_pending, m_ie, m_irq;
    int m_cnt;

    function automatic logic [31:0] exp_word();
        logic [31:0] w;
        w = '0;
        if (address_dmem == BASE) begin
            w[0]   = m_level;
            w[1]   = m_pending;
            w[2]   = m_ie;
            w[9:8] = 2'(m_cnt);
        end
        return w;
    endfunction

    task automatic model_step();
        bit s_now, new_level, all_same, press, is_sel, pend_next;
        if (reset) begin
            m_b1 = 0; m_b2 = 0; hist.delete();
            m_level = 0; m_pending = 0; m_cnt = 0; m_ie = 0; m_irq = 0;
            return;
        end
        s_now = m_b2;
        hist.push_front(s_now);
        if (hist.size() > D) void'(hist.pop_back());
        all_same = (hist.size() == D);
        foreach (hist[i]) if (hist[i] != s_now) all_same = 0;
        new_level = (all_same && s_now != m_level) ? s_now : m_level;
        press  = !m_level && new_level;
        is_sel = (address_dmem == BASE);
        pend_next = press ? 1'b1 : ((is_sel && (rd_strobe || (wren && data[0]))) ? 1'b0 : m_pending);
        if (is_sel && wren && data[1]) m_cnt = press ? 1 : 0;
        else if (press && m_cnt < (1 << CW) - 1) m_cnt = m_cnt + 1;
`ifdef BUTTON_MMIO_IRQ_EN
        m_irq = pend_next && m_ie;
        if (is_sel && wren) m_ie = data[2];
`endif
        m_pending = pend_next;
        m_level   = new_level;
        m_b2      = m_b1;
        m_b1      = button_in;
    endtask

    // Inputs are applied at the negedge before calling; compares pre-edge state.
    task automatic tick();
        #1;
        check_value("sel", {31'd0, sel}, {31'd0, address_dmem == BASE});
        check_value("q_button", q_button, exp_word());
`ifdef BUTTON_MMIO_IRQ_EN
        check_value("irq", {31'd0, irq}, {31'd0, m_irq});
`endif
        @(posedge clock);
        model_step();
        @(negedge clock);
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int edges;
        bit seen;
        int run_len;

        reset = 1; button_in = 0; address_dmem = BASE; wren = 0; data = '0; rd_strobe = 0;
        @(negedge clock);
        hold(2);
        reset = 0;
        tick();
        check_value("reset_word", q_button, 32'h0);

        // Clean press latency and read word
        button_in = 1;
        edges = 0; seen = 0;
        while (!seen && edges < 40) begin
            tick();
            edges++;
            seen = q_button[0];
        end
        check_value("press_latency", edges, D + 2);
        check_value("clean_press_word", q_button, 32'h0000_0103);

        // Read-to-clear at base, then a miss at base-1
        rd_strobe = 1;
        tick();
        rd_strobe = 0;
        #1 check_value("after_read_clear", q_button, 32'h0000_0101);
        address_dmem = BASE - 1;
        #1 check_value("miss_word", q_button, 32'h0);
        rd_strobe = 1;
        tick();
        rd_strobe = 0;

        // Saturation: several more presses with the bus idle
        address_dmem = 32'd0;
        button_in = 0;
        hold(2 * D + 4);
        for (int p = 0; p < 5; p++) begin
            button_in = 1; hold(2 * D + 4);
            button_in = 0; hold(2 * D + 4);
        end
        address_dmem = BASE;
        #1 check_value("saturated_count", {30'd0, q_button[9:8]}, 32'd3);

        // Glitch shorter than the debounce window
        button_in = 1; hold(3);
        button_in = 0; hold(2 * D + 4);
        #1 check_value("glitch_level", {31'd0, q_button[0]}, 32'd0);

        // Store clearing the count only
        wren = 1; data = 32'h2;
        tick();
        wren = 0; data = '0;
        #1 check_value("store_clear_cnt", {30'd0, q_button[9:8]}, 32'd0);

        // Randomised traffic
        run_len = 0;
        for (int c = 0; c < 4000; c++) begin
            if (run_len == 0) begin
                button_in = $urandom_range(0, 1);
                run_len   = $urandom_range(1, 2 * D + 3);
            end
            run_len--;
            case ($urandom_range(0, 3))
                0, 1:    address_dmem = BASE;
                2:       address_dmem = BASE - 1;
                default: address_dmem = $urandom;
            endcase
            wren      = ($urandom_range(0, 15) == 0);
            rd_strobe = ($urandom_range(0, 7) == 0);
            data      = $urandom;
            reset     = ($urandom_range(0, 399) == 0);
            tick();
        end

        reset = 0; wren = 0; rd_strobe = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
